can_frame_rx: RTL and testbench

//  Bit-level classic CAN (2.0A, base format) frame receiver on the node side of a can_transciever.

---
 rtl/can_rx_pkg.sv | 40 ++++
 rtl/can_bit_timing.sv | 52 +++++
 rtl/can_frame_rx.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_can_frame_rx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_rx_pkg.sv
// Shared definitions for the classic CAN (2.0A) frame receiver.
//   state_t        receiver FSM states
//   CAN_CRC15_POLY CRC15 generator polynomial
//   *_LEN          fixed field lengths in bits
//   crc15_next     single-bit serial CRC15 update
package can_rx_pkg;

   localparam int unsigned ID_LEN    = 11;
   localparam int unsigned DLC_LEN   = 4;
   localparam int unsigned CRC_LEN   = 15;
   localparam int unsigned EOF_LEN   = 7;
   localparam int unsigned INTEG_LEN = 11;

   localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;

   typedef enum logic [3:0] {
      ST_INTEGRATE,
      ST_IDLE,
      ST_ARB,
      ST_CTRL,
      ST_DATA,
      ST_CRC,
      ST_CRC_DEL,
      ST_ACK,
      ST_ACK_DEL,
      ST_EOF,
      ST_ERROR
   } state_t;

   // Shift one bus bit into the CRC register (MSB-first, feedback on bit 14).
   function automatic logic [14:0] crc15_next(input logic [14:0] crc, input logic b);
      logic [14:0] s;
      s = {crc[13:0], 1'b0};
      if (b ^ crc[14]) begin
         s = s ^ CAN_CRC15_POLY;
      end
      return s;
   endfunction

endpackage

// File: rtl/can_bit_timing.sv
// Bit timing for the CAN receiver.
//   clk, rst     clock and asynchronous active-high reset
//   can_rx       raw bus level (0 = dominant)
//   sync_en      1 = falling edges on the synchronised line restart the bit
//   rx_bit       synchronised bus level (2-clock latency)
//   sample_c     strobe at the sample point of the current bit
//   bit_start_c  strobe on the last clock of a bit; the next clock is count 0
module can_bit_timing #(
   parameter int unsigned CLK_PER_BIT = 10,
   parameter int unsigned SAMPLE_PT   = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic can_rx,
   input  logic sync_en,
   output logic rx_bit,
   output logic sample_c,
   output logic bit_start_c
);

   localparam int unsigned CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

   logic             rx_meta;
   logic             rx_prev;
   logic [CNT_W-1:0] cnt;
   logic             fall;

   // Every recessive-to-dominant edge realigns the bit; no jump-width limit.
   assign fall        = sync_en & rx_prev & ~rx_bit;
   assign sample_c    = (cnt == CNT_W'(SAMPLE_PT));
   assign bit_start_c = fall | (cnt == CNT_W'(CLK_PER_BIT - 1));

   // Two-flop synchroniser, edge history and bit counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_bit  <= 1'b1;
         rx_prev <= 1'b1;
         cnt     <= '0;
      end else begin
         rx_meta <= can_rx;
         rx_bit  <= rx_meta;
         rx_prev <= rx_bit;
         if (bit_start_c) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/can_frame_rx.sv
// Classic CAN 2.0A base-format frame receiver (passive, never sends error frames).
//   clk_i, rst_i   clock and asynchronous active-high reset
//   can_rx_i       bus level from the transceiver (0 = dominant)
//   can_tx_o       bus drive; only ever dominant in the ACK slot
//   ack_en_i       1 = acknowledge frames with a good CRC
//   frm_*          single-entry output slot with valid/ready handshake
//   err_stuff_o    pulse: stuff rule violated
//   err_form_o     pulse: fixed-form bit was dominant
//   err_crc_o      pulse: CRC mismatch (at the CRC delimiter)
//   overflow_o     pulse: good frame dropped, slot still occupied
module can_frame_rx
   import can_rx_pkg::*;
#(
   parameter int unsigned CLK_PER_BIT = 10,
   parameter int unsigned SAMPLE_PT   = 7
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        can_rx_i,
   output logic        can_tx_o,
   input  logic        ack_en_i,
   output logic        frm_valid_o,
   input  logic        frm_ready_i,
   output logic [10:0] frm_id_o,
   output logic        frm_rtr_o,
   output logic [3:0]  frm_dlc_o,
   output logic [63:0] frm_data_o,
   output logic        err_stuff_o,
   output logic        err_form_o,
   output logic        err_crc_o,
   output logic        overflow_o
);

   logic rx_bit;
   logic sample_c;
   logic bit_start_c;

   // Resync is suppressed while we drive ACK so our own edge does not move the bit.
   can_bit_timing #(
      .CLK_PER_BIT (CLK_PER_BIT),
      .SAMPLE_PT   (SAMPLE_PT)
   ) u_timing (
      .clk         (clk_i),
      .rst         (rst_i),
      .can_rx      (can_rx_i),
      .sync_en     (can_tx_o),
      .rx_bit      (rx_bit),
      .sample_c    (sample_c),
      .bit_start_c (bit_start_c)
   );

   state_t        state,    state_n;
   logic [6:0]    bit_cnt,  bit_cnt_n;
   logic          run_val,  run_val_n;
   logic [2:0]    run_cnt,  run_cnt_n;
   logic [14:0]   crc_calc, crc_calc_n;
   logic [14:0]   crc_rx,   crc_rx_n;
   logic [10:0]   id_q,     id_n;
   logic          rtr_q,    rtr_n;
   logic [3:0]    dlc_q,    dlc_n;
   logic [63:0]   data_q,   data_n;
   logic          crc_ok,   crc_ok_n;
   logic          ack_pend, ack_pend_n;
   logic          err_stuff_n, err_form_n, err_crc_n;
   logic          commit_c;
   logic          stuff_bit;
   logic          stuff_zone;
   logic [3:0]    dlc_shift;
   logic [6:0]    data_bits;
   logic [5:0]    data_idx;

   // Destuffing covers SOF..last CRC bit, including a stuff bit that trails the CRC.
   assign stuff_zone = (state == ST_ARB) || (state == ST_CTRL) || (state == ST_DATA) ||
                       (state == ST_CRC) || ((state == ST_CRC_DEL) && (run_cnt == 3'd5));
   assign dlc_shift  = {dlc_q[2:0], rx_bit};
   // DLC 9..15 still carries 8 bytes.
   assign data_bits  = dlc_q[3] ? 7'd64 : 7'({dlc_q[2:0], 3'b000});
   // Bytes fill from byte0 = [7:0], each byte arrives MSB first.
   assign data_idx   = {bit_cnt[5:3], ~bit_cnt[2:0]};

   // State and frame registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ST_INTEGRATE;
         bit_cnt     <= '0;
         run_val     <= 1'b1;
         run_cnt     <= '0;
         crc_calc    <= '0;
         crc_rx      <= '0;
         id_q        <= '0;
         rtr_q       <= 1'b0;
         dlc_q       <= '0;
         data_q      <= '0;
         crc_ok      <= 1'b0;
         ack_pend    <= 1'b0;
         err_stuff_o <= 1'b0;
         err_form_o  <= 1'b0;
         err_crc_o   <= 1'b0;
      end else begin
         state       <= state_n;
         bit_cnt     <= bit_cnt_n;
         run_val     <= run_val_n;
         run_cnt     <= run_cnt_n;
         crc_calc    <= crc_calc_n;
         crc_rx      <= crc_rx_n;
         id_q        <= id_n;
         rtr_q       <= rtr_n;
         dlc_q       <= dlc_n;
         data_q      <= data_n;
         crc_ok      <= crc_ok_n;
         ack_pend    <= ack_pend_n;
         err_stuff_o <= err_stuff_n;
         err_form_o  <= err_form_n;
         err_crc_o   <= err_crc_n;
      end
   end

   // Next-state, destuffer, CRC and field capture; everything advances on the sample strobe.
   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      run_val_n   = run_val;
      run_cnt_n   = run_cnt;
      crc_calc_n  = crc_calc;
      crc_rx_n    = crc_rx;
      id_n        = id_q;
      rtr_n       = rtr_q;
      dlc_n       = dlc_q;
      data_n      = data_q;
      crc_ok_n    = crc_ok;
      ack_pend_n  = ack_pend;
      err_stuff_n = 1'b0;
      err_form_n  = 1'b0;
      err_crc_n   = 1'b0;
      commit_c    = 1'b0;
      stuff_bit   = 1'b0;

      if (sample_c) begin
         if (stuff_zone) begin
            if (run_cnt == 3'd5) begin
               stuff_bit = 1'b1;
               if (rx_bit == run_val) begin
                  err_stuff_n = 1'b1;
                  state_n     = ST_ERROR;
                  bit_cnt_n   = '0;
               end else begin
                  run_val_n = rx_bit;
                  run_cnt_n = 3'd1;
               end
            end else if (rx_bit == run_val) begin
               run_cnt_n = run_cnt + 3'd1;
            end else begin
               run_val_n = rx_bit;
               run_cnt_n = 3'd1;
            end
         end

         if (!stuff_bit) begin
            case (state)
               ST_INTEGRATE, ST_ERROR: begin
                  if (!rx_bit) begin
                     bit_cnt_n = '0;
                  end else if (bit_cnt == 7'(INTEG_LEN - 1)) begin
                     state_n   = ST_IDLE;
                     bit_cnt_n = '0;
                  end else begin
                     bit_cnt_n = bit_cnt + 7'd1;
                  end
               end
               ST_IDLE: begin
                  if (!rx_bit) begin
                     state_n    = ST_ARB;
                     bit_cnt_n  = '0;
                     run_val_n  = 1'b0;
                     run_cnt_n  = 3'd1;
                     crc_calc_n = crc15_next(15'd0, 1'b0);
                     id_n       = '0;
                     rtr_n      = 1'b0;
                     dlc_n      = '0;
                     data_n     = '0;
                     crc_ok_n   = 1'b0;
                     ack_pend_n = 1'b0;
                  end
               end
               ST_ARB: begin
                  crc_calc_n = crc15_next(crc_calc, rx_bit);
                  if (bit_cnt == 7'(ID_LEN)) begin
                     rtr_n     = rx_bit;
                     state_n   = ST_CTRL;
                     bit_cnt_n = '0;
                  end else begin
                     id_n      = {id_q[9:0], rx_bit};
                     bit_cnt_n = bit_cnt + 7'd1;
                  end
               end
               // Bit 0 = IDE, bit 1 = r0, bits 2..5 = DLC.
               ST_CTRL: begin
                  crc_calc_n = crc15_next(crc_calc, rx_bit);
                  if ((bit_cnt == 7'd0) && rx_bit) begin
                     err_form_n = 1'b1;
                     state_n    = ST_ERROR;
                     bit_cnt_n  = '0;
                  end else if (bit_cnt == 7'(DLC_LEN + 1)) begin
                     dlc_n     = dlc_shift;
                     bit_cnt_n = '0;
                     if (!rtr_q && (dlc_shift != 4'd0)) begin
                        state_n = ST_DATA;
                     end else begin
                        state_n = ST_CRC;
                     end
                  end else begin
                     if (bit_cnt >= 7'd2) begin
                        dlc_n = dlc_shift;
                     end
                     bit_cnt_n = bit_cnt + 7'd1;
                  end
               end
               ST_DATA: begin
                  crc_calc_n       = crc15_next(crc_calc, rx_bit);
                  data_n[data_idx] = rx_bit;
                  if (bit_cnt == (data_bits - 7'd1)) begin
                     state_n   = ST_CRC;
                     bit_cnt_n = '0;
                  end else begin
                     bit_cnt_n = bit_cnt + 7'd1;
                  end
               end
               ST_CRC: begin
                  crc_rx_n = {crc_rx[13:0], rx_bit};
                  if (bit_cnt == 7'(CRC_LEN - 1)) begin
                     state_n   = ST_CRC_DEL;
                     bit_cnt_n = '0;
                  end else begin
                     bit_cnt_n = bit_cnt + 7'd1;
                  end
               end
               ST_CRC_DEL: begin
                  if (!rx_bit) begin
                     err_form_n = 1'b1;
                     state_n    = ST_ERROR;
                     bit_cnt_n  = '0;
                  end else begin
                     crc_ok_n   = (crc_calc == crc_rx);
                     err_crc_n  = (crc_calc != crc_rx);
                     ack_pend_n = (crc_calc == crc_rx) && ack_en_i;
                     state_n    = ST_ACK;
                  end
               end
               ST_ACK: begin
                  state_n = ST_ACK_DEL;
               end
               ST_ACK_DEL: begin
                  bit_cnt_n = '0;
                  if (!rx_bit) begin
                     err_form_n = 1'b1;
                     state_n    = ST_ERROR;
                  end else begin
                     state_n = ST_EOF;
                  end
               end
               ST_EOF: begin
                  if (!rx_bit) begin
                     err_form_n = 1'b1;
                     state_n    = ST_ERROR;
                     bit_cnt_n  = '0;
                  end else if (bit_cnt == 7'(EOF_LEN - 1)) begin
                     commit_c  = crc_ok;
                     state_n   = ST_IDLE;
                     bit_cnt_n = '0;
                  end else begin
                     bit_cnt_n = bit_cnt + 7'd1;
                  end
               end
               default: begin
                  state_n   = ST_INTEGRATE;
                  bit_cnt_n = '0;
               end
            endcase
         end
      end
   end

   // ACK drive: dominant from the bit boundary entering ACK for one full bit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         can_tx_o <= 1'b1;
      end else if (bit_start_c) begin
         if (!can_tx_o) begin
            can_tx_o <= 1'b1;
         end else if ((state == ST_ACK) && ack_pend) begin
            can_tx_o <= 1'b0;
         end
      end
   end

   // Single-entry output slot; a commit into a full slot that is not draining is dropped.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         frm_valid_o <= 1'b0;
         frm_id_o    <= '0;
         frm_rtr_o   <= 1'b0;
         frm_dlc_o   <= '0;
         frm_data_o  <= '0;
         overflow_o  <= 1'b0;
      end else begin
         overflow_o <= 1'b0;
         if (commit_c && (!frm_valid_o || frm_ready_i)) begin
            frm_valid_o <= 1'b1;
            frm_id_o    <= id_q;
            frm_rtr_o   <= rtr_q;
            frm_dlc_o   <= dlc_q;
            frm_data_o  <= data_q;
         end else begin
            if (commit_c) begin
               overflow_o <= 1'b1;
            end
            if (frm_valid_o && frm_ready_i) begin
               frm_valid_o <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_can_frame_rx.sv
// Self-checking bench for can_frame_rx: encodes frames (CRC15 + bit stuffing) from
// their field values, drives them bit by bit and checks the receiver against a
// queue of expected frames plus error/ACK counters.
`timescale 1ns/1ps
module tb_can_frame_rx;

   localparam int unsigned CPB = 10;
   localparam int unsigned SP  = 7;

   typedef bit bitq_t[$];
   typedef struct {
      logic [10:0] id;
      logic        rtr;
      logic [3:0]  dlc;
      logic [63:0] data;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst, can_rx, can_tx, ack_en, frm_valid, frm_ready, frm_rtr;
   logic [10:0] frm_id;
   logic [3:0]  frm_dlc;
   logic [63:0] frm_data;
   logic        err_stuff, err_form, err_crc, overflow;

   int n_checks = 0;
   int n_pass   = 0;
   int n_stuff = 0, n_form = 0, n_crc = 0, n_ovf = 0, n_rx = 0;
   int ack_pulses = 0, low_run = 0, last_ack_w = 0;
   frame_t exp_q[$];
   frame_t last_rx;

   always #5 clk = ~clk;

   can_frame_rx #(.CLK_PER_BIT(CPB), .SAMPLE_PT(SP)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .can_rx_i    (can_rx),
      .can_tx_o    (can_tx),
      .ack_en_i    (ack_en),
      .frm_valid_o (frm_valid),
      .frm_ready_i (frm_ready),
      .frm_id_o    (frm_id),
      .frm_rtr_o   (frm_rtr),
      .frm_dlc_o   (frm_dlc),
      .frm_data_o  (frm_data),
      .err_stuff_o (err_stuff),
      .err_form_o  (err_form),
      .err_crc_o   (err_crc),
      .overflow_o  (overflow)
   );

   task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic int n_bytes(input logic rtr, input logic [3:0] dlc);
      if (rtr) return 0;
      return (dlc > 4'd8) ? 8 : int'(dlc);
   endfunction

   function automatic logic [14:0] crc15(input bitq_t u);
      logic [14:0] c = 15'd0;
      bit fb;
      foreach (u[i]) begin
         fb = u[i] ^ c[14];
         c  = {c[13:0], 1'b0};
         if (fb) c = c ^ 15'h4599;
      end
      return c;
   endfunction

   function automatic bitq_t stuff(input bitq_t u);
      bitq_t s;
      bit    prev = 1'b1;
      int    run  = 0;
      foreach (u[i]) begin
         s.push_back(u[i]);
         if (u[i] == prev) run++;
         else begin prev = u[i]; run = 1; end
         if (run == 5) begin s.push_back(~prev); prev = ~prev; run = 1; end
      end
      return s;
   endfunction

   // SOF..CRC, stuffed; flip >= 0 corrupts that CRC bit before stuffing.
   function automatic bitq_t build(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                                   input logic [63:0] pl, input int flip);
      bitq_t u;
      logic [14:0] c;
      u.push_back(1'b0);
      for (int i = 10; i >= 0; i--) u.push_back(id[i]);
      u.push_back(rtr);
      u.push_back(1'b0);
      u.push_back(1'b0);
      for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
      for (int k = 0; k < n_bytes(rtr, dlc); k++)
         for (int i = 7; i >= 0; i--) u.push_back(pl[k*8 + i]);
      c = crc15(u);
      if (flip >= 0) c[flip] = ~c[flip];
      for (int i = 14; i >= 0; i--) u.push_back(c[i]);
      return stuff(u);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input bitq_t q);
      foreach (q[i]) begin
         can_rx = q[i];
         tick(CPB);
      end
   endtask

   task automatic idle(input int nbits);
      can_rx = 1'b1;
      tick(nbits * CPB);
   endtask

   task automatic send_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                             input logic [63:0] pl, input int flip, input bit expect_rx);
      bitq_t  q;
      frame_t f;
      q = build(id, rtr, dlc, pl, flip);
      if (expect_rx) begin
         f.id = id; f.rtr = rtr; f.dlc = dlc; f.data = '0;
         for (int k = 0; k < n_bytes(rtr, dlc); k++) f.data[k*8 +: 8] = pl[k*8 +: 8];
         exp_q.push_back(f);
      end
      // CRC delimiter, ACK slot (sent recessive), ACK delimiter, 7 EOF bits
      for (int i = 0; i < 10; i++) q.push_back(1'b1);
      drive(q);
      idle(3);
   endtask

   // Per-cycle compare against the expected-frame queue, plus event counters.
   always @(negedge clk) begin
      if (!rst) begin
         if (!can_tx) low_run++;
         else if (low_run != 0) begin ack_pulses++; last_ack_w = low_run; low_run = 0; end
         if (err_stuff) n_stuff++;
         if (err_form)  n_form++;
         if (err_crc)   n_crc++;
         if (overflow)  n_ovf++;
         if (frm_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 80'(frm_valid), 80'(0));
            end else begin
               check("frame", {frm_id, frm_rtr, frm_dlc, frm_data},
                     {exp_q[0].id, exp_q[0].rtr, exp_q[0].dlc, exp_q[0].data});
               if (frm_ready) begin
                  last_rx = '{frm_id, frm_rtr, frm_dlc, frm_data};
                  void'(exp_q.pop_front());
                  n_rx++;
               end
            end
         end
      end else begin
         low_run = 0;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   initial begin
      bitq_t q, t;
      int a0, r0, c0;
      rst = 1'b1; can_rx = 1'b1; ack_en = 1'b1; frm_ready = 1'b1;
      tick(3);
      check("rst_tx", 80'(can_tx), 80'(1));
      check("rst_slot", {frm_valid, frm_id, frm_rtr, frm_dlc, frm_data}, 80'(0));
      check("rst_pulses", 80'({err_stuff, err_form, err_crc, overflow}), 80'(0));
      rst = 1'b0;

      // Pin the encoder model with hand-computed values.
      q = {1'b1};
      check("crc_pin1", 80'(crc15(q)), 80'(15'h4599));
      q = {1'b1, 1'b0};
      check("crc_pin2", 80'(crc15(q)), 80'(15'h4EAB));
      q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      t = stuff(q);
      check("stuff_pin_len", 80'(t.size()), 80'(7));
      check("stuff_pin_bit", 80'(t[5]), 80'(1));

      idle(12);

      // 1: basic frame with ACK
      a0 = ack_pulses;
      send_frame(11'h123, 1'b0, 4'd2, 64'h5AA5, -1, 1'b1);
      idle(2);
      check("t1_rx", 80'(n_rx), 80'(1));
      check("t1_data", 80'(last_rx.data), 80'(64'h5AA5));
      check("t1_id_dlc", 80'({last_rx.id, last_rx.dlc}), 80'({11'h123, 4'd2}));
      check("t1_ack_cnt", 80'(ack_pulses - a0), 80'(1));
      check("t1_ack_width", 80'(last_ack_w), 80'(CPB));

      // 2: heavy stuffing, then a stuff violation inside the ID
      send_frame(11'h000, 1'b0, 4'd8, 64'h0, -1, 1'b1);
      idle(2);
      check("t2_rx", 80'(n_rx), 80'(2));
      check("t2_data", 80'(last_rx.data), 80'(0));
      check("t2_no_err", 80'(n_stuff + n_form + n_crc), 80'(0));
      q = build(11'h000, 1'b0, 4'd8, 64'h0, -1);
      t = q[0:5];
      t[5] = 1'b0;
      drive(t);
      idle(14);
      check("t2_stuff_err", 80'(n_stuff), 80'(1));
      check("t2_no_rx", 80'(n_rx), 80'(2));
      send_frame(11'h7F0, 1'b0, 4'd1, 64'hFF, -1, 1'b1);
      idle(2);
      check("t2_recover", 80'(n_rx), 80'(3));

      // 3: corrupted CRC bit
      a0 = ack_pulses; r0 = n_rx;
      send_frame(11'h123, 1'b0, 4'd2, 64'h5AA5, 3, 1'b0);
      idle(2);
      check("t3_crc_err", 80'(n_crc), 80'(1));
      check("t3_no_ack", 80'(ack_pulses - a0), 80'(0));
      check("t3_no_rx", 80'(n_rx - r0), 80'(0));

      // 4: back-to-back frames into a stalled consumer
      frm_ready = 1'b0;
      r0 = n_rx;
      send_frame(11'h0AB, 1'b0, 4'd1, 64'h3C, -1, 1'b1);
      send_frame(11'h0CD, 1'b0, 4'd0, 64'h0, -1, 1'b0);
      idle(2);
      check("t4_overflow", 80'(n_ovf), 80'(1));
      check("t4_held", 80'(frm_valid), 80'(1));
      frm_ready = 1'b1;
      tick(3);
      check("t4_rx", 80'(n_rx - r0), 80'(1));
      check("t4_drained", 80'(frm_valid), 80'(0));
      check("t4_id", 80'(last_rx.id), 80'(11'h0AB));

      // 5: DLC above 8, ACK disabled; then a remote frame
      ack_en = 1'b0;
      a0 = ack_pulses;
      send_frame(11'h456, 1'b0, 4'hF, 64'h0807060504030201, -1, 1'b1);
      idle(2);
      check("t5_data", 80'(last_rx.data), 80'(64'h0807060504030201));
      check("t5_dlc", 80'(last_rx.dlc), 80'(15));
      check("t5_no_ack", 80'(ack_pulses - a0), 80'(0));
      ack_en = 1'b1;
      send_frame(11'h456, 1'b1, 4'd3, 64'hFFFFFF, -1, 1'b1);
      idle(2);
      check("t5_rtr", 80'({last_rx.rtr, last_rx.dlc}), 80'({1'b1, 4'd3}));
      check("t5_rtr_data", 80'(last_rx.data), 80'(0));

      // 6: reset in the middle of a data field
      frm_ready = 1'b0;
      send_frame(11'h321, 1'b0, 4'd1, 64'h99, -1, 1'b1);
      q = build(11'h222, 1'b0, 4'd4, 64'h44332211, -1);
      t = q[0:29];
      drive(t);
      rst = 1'b1;
      exp_q.delete();
      tick(2);
      check("t6_rst_tx", 80'(can_tx), 80'(1));
      check("t6_rst_slot", {frm_valid, frm_id, frm_rtr, frm_dlc, frm_data}, 80'(0));
      rst = 1'b0;
      frm_ready = 1'b1;
      r0 = n_rx; c0 = n_stuff + n_form + n_crc;
      idle(2);
      send_frame(11'h155, 1'b0, 4'd1, 64'h12, -1, 1'b0);
      idle(1);
      check("t6_integrate", 80'(n_rx - r0), 80'(0));
      tick(5);
      send_frame(11'h2AA, 1'b0, 4'd2, 64'hBEEF, -1, 1'b1);
      tick(3);
      send_frame(11'h0F5, 1'b0, 4'd3, 64'hC0FFEE, -1, 1'b1);
      idle(2);
      check("t6_shifted_rx", 80'(n_rx - r0), 80'(2));
      check("t6_last", 80'({last_rx.id, last_rx.data}), 80'({11'h0F5, 64'hC0FFEE}));
      check("t6_no_err", 80'(n_stuff + n_form + n_crc - c0), 80'(0));

      check("form_total", 80'(n_form), 80'(0));
      check("queue_empty", 80'(exp_q.size()), 80'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
